// File: rtl/vram_pixel_writer.sv
// ---------------------------------------------------------------------------
// vram_pixel_writer
//
// Write path into the 640x480, 8-bpp frame buffer. Single-pixel draw requests
// are queued in a small FIFO and turned into byte-lane SRAM write cycles. Each
// 16-bit SRAM word holds two horizontally adjacent pixels: even x in the low
// byte, odd x in the high byte. The bus is used only while the arbiter grants
// it, and the grant is looked at only when a new cycle could start.
//
// Ports
//   CLK_50, RESET_N       clock, asynchronous active-low reset
//   px_valid/px_ready     request handshake (push on valid & ready)
//   px_x, px_y, px_color  request payload: column, row, palette index
//   sram_grant            arbiter permits starting a new SRAM cycle
//   busy                  FIFO non-empty or SRAM cycle in progress
//   drop_count            saturating count of out-of-range requests
//   SRAM_*                registered SRAM strobes, address and write data
//   SRAM_DQ_OUT/_OE       write data and drive enable for the top tristate
// ---------------------------------------------------------------------------
module vram_pixel_writer #(
  parameter int         FIFO_DEPTH  = 16,
  parameter int         SCREEN_W    = 640,
  parameter int         SCREEN_H    = 480,
  parameter logic [7:0] TRANSPARENT = 8'hFC,
  parameter int         WE_CYCLES   = 2
) (
  input  logic        CLK_50,
  input  logic        RESET_N,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic [9:0]  px_x,
  input  logic [9:0]  px_y,
  input  logic [7:0]  px_color,
  input  logic        sram_grant,
  output logic        busy,
  output logic [7:0]  drop_count,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic [19:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_OUT,
  output logic        SRAM_DQ_OE
);

  localparam int          AW     = $clog2(FIFO_DEPTH);
  localparam int          CW     = AW + 1;
  localparam int          WCW    = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [10:0] X_LIM  = 11'(SCREEN_W);
  localparam logic [10:0] Y_LIM  = 11'(SCREEN_H);
  localparam logic [19:0] HALF_W = 20'(SCREEN_W / 2);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WRITE, S_HOLD} state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] color;
  } px_req_t;

  // ---------------- request FIFO ----------------
  px_req_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count, w_count_next;
  logic             r_px_ready;
  logic             w_push, w_pop;
  px_req_t          w_head;

  state_t           r_state, w_state_next;

  // ready comes from the registered count only, so a full FIFO refuses a
  // push even when the same cycle pops.
  assign w_push   = px_valid & r_px_ready;
  assign w_pop    = (r_state == S_IDLE) && (r_count != '0) && sram_grant;
  assign w_head   = r_mem[r_rd_ptr];
  assign px_ready = r_px_ready;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_px_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count    <= w_count_next;
      r_px_ready <= (w_count_next != CW'(FIFO_DEPTH));
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by r_count,
  // so stale entries are never observed and the array can map to RAM.
  always_ff @(posedge CLK_50) begin
    if (w_push) r_mem[r_wr_ptr] <= '{x: px_x, y: px_y, color: px_color};
  end

  // ---------------- head classification ----------------
  logic        w_oob, w_accept, w_load;
  logic [19:0] w_addr;

  assign w_oob    = ({1'b0, w_head.x} >= X_LIM) || ({1'b0, w_head.y} >= Y_LIM);
  assign w_accept = !w_oob && (w_head.color != TRANSPARENT);
  assign w_load   = w_pop && w_accept;
  assign w_addr   = 20'(w_head.y) * HALF_W + 20'(w_head.x[9:1]);

  logic [7:0] r_drop_count;

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_drop_count <= '0;
    end else if (w_pop && w_oob && (r_drop_count != 8'hFF)) begin
      r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign drop_count = r_drop_count;

  // ---------------- write-cycle FSM ----------------
  logic [WCW-1:0] r_we_cnt;

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= S_IDLE;
      r_we_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_we_cnt <= (r_state == S_WRITE) ? r_we_cnt + WCW'(1) : '0;
    end
  end

  // NOTE: every variable written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_load) w_state_next = S_SETUP;
      S_SETUP: w_state_next = S_WRITE;
      S_WRITE: if (r_we_cnt == WCW'(WE_CYCLES - 1)) w_state_next = S_HOLD;
      S_HOLD:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Strobe values for the state being entered; registered below so the SRAM
  // pins change only on state entry and never glitch.
  logic w_ce_n_next, w_we_n_next, w_dq_oe_next;

  always_comb begin
    w_ce_n_next  = (w_state_next == S_IDLE);
    w_we_n_next  = (w_state_next != S_WRITE);
    w_dq_oe_next = (w_state_next != S_IDLE);
  end

  logic        r_ce_n, r_we_n, r_ub_n, r_lb_n, r_dq_oe;
  logic [19:0] r_addr;
  logic [15:0] r_dq;

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ce_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_ub_n  <= 1'b1;
      r_lb_n  <= 1'b1;
      r_dq_oe <= 1'b0;
      r_addr  <= '0;
      r_dq    <= '0;
    end else begin
      r_ce_n  <= w_ce_n_next;
      r_we_n  <= w_we_n_next;
      r_dq_oe <= w_dq_oe_next;
      if (w_load) begin
        // address and data stay put from SETUP through HOLD
        r_addr <= w_addr;
        r_dq   <= {w_head.color, w_head.color};
        r_ub_n <= ~w_head.x[0];
        r_lb_n <= w_head.x[0];
      end else if (w_state_next == S_IDLE) begin
        r_ub_n <= 1'b1;
        r_lb_n <= 1'b1;
      end
    end
  end

  assign SRAM_CE_N   = r_ce_n;
  assign SRAM_OE_N   = 1'b1;
  assign SRAM_WE_N   = r_we_n;
  assign SRAM_UB_N   = r_ub_n;
  assign SRAM_LB_N   = r_lb_n;
  assign SRAM_ADDR   = r_addr;
  assign SRAM_DQ_OUT = r_dq;
  assign SRAM_DQ_OE  = r_dq_oe;

  assign busy = (r_count != '0) || (r_state != S_IDLE);

endmodule

// File: tb/tb_vram_pixel_writer.sv
// ---------------------------------------------------------------------------
// tb_vram_pixel_writer
//
// Directed stimulus pushes pixel requests and enqueues the SRAM write each
// one should produce. A monitor reconstructs every SRAM write cycle from the
// pins and compares it against the head of the expectation queue.
// ---------------------------------------------------------------------------
module tb_vram_pixel_writer;

  localparam int WE_CYC = 2;

  logic        CLK_50 = 1'b0;
  logic        RESET_N;
  logic        px_valid = 1'b0;
  logic        px_ready;
  logic [9:0]  px_x = '0;
  logic [9:0]  px_y = '0;
  logic [7:0]  px_color = '0;
  logic        sram_grant = 1'b0;
  logic        busy;
  logic [7:0]  drop_count;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
  logic [19:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_OUT;
  logic        SRAM_DQ_OE;

  vram_pixel_writer dut (
    .CLK_50      (CLK_50),
    .RESET_N     (RESET_N),
    .px_valid    (px_valid),
    .px_ready    (px_ready),
    .px_x        (px_x),
    .px_y        (px_y),
    .px_color    (px_color),
    .sram_grant  (sram_grant),
    .busy        (busy),
    .drop_count  (drop_count),
    .SRAM_CE_N   (SRAM_CE_N),
    .SRAM_OE_N   (SRAM_OE_N),
    .SRAM_WE_N   (SRAM_WE_N),
    .SRAM_UB_N   (SRAM_UB_N),
    .SRAM_LB_N   (SRAM_LB_N),
    .SRAM_ADDR   (SRAM_ADDR),
    .SRAM_DQ_OUT (SRAM_DQ_OUT),
    .SRAM_DQ_OE  (SRAM_DQ_OE)
  );

  always #10 CLK_50 = ~CLK_50;

  typedef struct {
    logic [19:0] addr;
    logic [15:0] dq;
    logic        ub_n;
    logic        lb_n;
  } wr_t;

  wr_t sb[$];
  int  checks   = 0;
  int  errors   = 0;
  int  n_writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_wr(input logic [19:0] addr, input logic [15:0] dq, input logic ub);
    wr_t e;
    e.addr = addr;
    e.dq   = dq;
    e.ub_n = ~ub;
    e.lb_n = ub;
    sb.push_back(e);
  endtask

  // Returns just after the capturing clock edge.
  task automatic push_px(input logic [9:0] x, input logic [9:0] y, input logic [7:0] c);
    logic got;
    got = 1'b0;
    @(posedge CLK_50); #1;
    px_valid = 1'b1; px_x = x; px_y = y; px_color = c;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK_50);
      if (px_ready) begin got = 1'b1; break; end
    end
    if (got) @(posedge CLK_50);
    #1 px_valid = 1'b0;
    check("push_accepted", got, 1);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK_50);
      if (!busy && SRAM_CE_N) begin ok = 1'b1; break; end
    end
    check("idle_reached", ok, 1);
    repeat (2) @(negedge CLK_50);
  endtask

  task automatic count_ce_low(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK_50);
      if (!SRAM_CE_N) n++;
    end
  endtask

  // ---------------- monitor ----------------
  logic        in_cyc = 1'b0;
  logic [19:0] cap_addr;
  logic [15:0] cap_dq;
  logic        cap_ub_n, cap_lb_n, first_we, last_we, stable;
  int          ce_len, we_len;
  wr_t         e_mon;

  always @(negedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      in_cyc = 1'b0;    // a write cut short by reset is not a write
    end else if (!in_cyc) begin
      if (!SRAM_CE_N) begin
        in_cyc   = 1'b1;
        cap_addr = SRAM_ADDR;
        cap_dq   = SRAM_DQ_OUT;
        cap_ub_n = SRAM_UB_N;
        cap_lb_n = SRAM_LB_N;
        first_we = SRAM_WE_N;
        last_we  = SRAM_WE_N;
        ce_len   = 1;
        we_len   = SRAM_WE_N ? 0 : 1;
        stable   = SRAM_DQ_OE & SRAM_OE_N;
      end
    end else if (!SRAM_CE_N) begin
      ce_len++;
      if (!SRAM_WE_N) we_len++;
      last_we = SRAM_WE_N;
      stable  = stable & (SRAM_ADDR == cap_addr) & (SRAM_DQ_OUT == cap_dq) &
                (SRAM_UB_N == cap_ub_n) & (SRAM_LB_N == cap_lb_n) &
                SRAM_DQ_OE & SRAM_OE_N;
    end else begin
      in_cyc = 1'b0;
      check("write_expected", sb.size() != 0, 1);
      check("dq_oe_off_after", SRAM_DQ_OE, 0);
      if (sb.size() != 0) begin
        e_mon = sb.pop_front();
        n_writes++;
        check("addr", cap_addr, e_mon.addr);
        check("data", cap_dq, e_mon.dq);
        check("ub_n", cap_ub_n, e_mon.ub_n);
        check("lb_n", cap_lb_n, e_mon.lb_n);
        check("ce_len", ce_len, WE_CYC + 2);
        check("we_len", we_len, WE_CYC);
        check("we_setup_hold_high", {first_we, last_we}, 2'b11);
        check("stable", stable, 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [5:0] ce_pat, we_pat, busy_pat;
  int         n;

  initial begin
    RESET_N = 1'b1;
    #3 RESET_N = 1'b0;
    #20;
    check("rst_px_ready", px_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_count, 0);
    check("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'b11111);
    check("rst_addr", SRAM_ADDR, 0);
    check("rst_dq", SRAM_DQ_OUT, 0);
    check("rst_dq_oe", SRAM_DQ_OE, 0);
    @(negedge CLK_50) RESET_N = 1'b1;
    @(negedge CLK_50);
    check("ready_after_rst", px_ready, 1);

    // 1: single pixel, exact cycle-by-cycle timing after the capture edge.
    // cycle:      1 2 3 4 5 6  (1=pop, 2=SETUP, 3..4=WRITE, 5=HOLD, 6=IDLE)
    sram_grant = 1'b1;
    ce_pat   = 6'b100001;   // bit k-1 = cycle k
    we_pat   = 6'b110011;
    busy_pat = 6'b011111;
    exp_wr(20'd641, 16'h1A1A, 1'b1);
    push_px(10'd3, 10'd2, 8'h1A);
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK_50);
      check("t1_ce_n", SRAM_CE_N, ce_pat[k]);
      check("t1_we_n", SRAM_WE_N, we_pat[k]);
      check("t1_busy", busy, busy_pat[k]);
    end
    wait_idle();

    // 2: last word of the frame, both halves
    exp_wr(20'd153599, 16'h0505, 1'b0);
    exp_wr(20'd153599, 16'h0505, 1'b1);
    push_px(10'd638, 10'd479, 8'h05);
    push_px(10'd639, 10'd479, 8'h05);
    wait_idle();

    // 3: fill the FIFO with no grant, refuse the 17th, then drain in order
    sram_grant = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_wr(20'd3200 + 20'(i / 2), {2{8'h20 + 8'(i)}}, i[0]);
      push_px(10'(i), 10'd10, 8'h20 + 8'(i));
    end
    @(posedge CLK_50); #1;
    px_valid = 1'b1; px_x = 10'd100; px_y = 10'd100; px_color = 8'h99;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK_50);
      check("full_ready_low", px_ready, 0);
    end
    @(posedge CLK_50); #1 px_valid = 1'b0;
    check("full_no_write", SRAM_CE_N, 1);
    sram_grant = 1'b1;
    wait_idle();
    check("ready_after_drain", px_ready, 1);

    // 4: discards: transparent, x out of range, y out of range
    exp_wr(20'd1602, 16'h3333, 1'b0);
    push_px(10'd1, 10'd1, 8'hFC);
    push_px(10'd640, 10'd0, 8'h01);
    push_px(10'd0, 10'd480, 8'h01);
    push_px(10'd4, 10'd5, 8'h33);
    wait_idle();
    check("drop_count_2", drop_count, 2);
    for (int i = 0; i < 300; i++) push_px(10'd1023, 10'(i), 8'h01);
    wait_idle();
    check("drop_count_sat", drop_count, 8'hFF);

    // 5: grant dropped during WRITE
    sram_grant = 1'b0;
    exp_wr(20'd5, 16'h4444, 1'b0);
    push_px(10'd10, 10'd0, 8'h44);
    push_px(10'd11, 10'd0, 8'h55);
    @(posedge CLK_50); #1 sram_grant = 1'b1;
    repeat (3) @(negedge CLK_50);
    check("t5_in_write", SRAM_WE_N, 0);
    sram_grant = 1'b0;
    for (int i = 0; i < 10 && !SRAM_CE_N; i++) @(negedge CLK_50);
    count_ce_low(20, n);
    check("t5_no_cycle_wo_grant", n, 0);
    check("t5_busy_pending", busy, 1);
    exp_wr(20'd5, 16'h5555, 1'b1);
    sram_grant = 1'b1;
    wait_idle();

    // 6: reset during WRITE aborts it and empties the FIFO
    sram_grant = 1'b0;
    push_px(10'd20, 10'd0, 8'h66);
    push_px(10'd22, 10'd0, 8'h77);
    @(posedge CLK_50); #1 sram_grant = 1'b1;
    repeat (3) @(negedge CLK_50);
    check("t6_in_write", SRAM_WE_N, 0);
    #2 RESET_N = 1'b0;
    #1;
    check("t6_async_we_ce", {SRAM_WE_N, SRAM_CE_N}, 2'b11);
    check("t6_async_dq_oe", SRAM_DQ_OE, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_ready", px_ready, 0);
    @(posedge CLK_50);
    @(negedge CLK_50) RESET_N = 1'b1;
    count_ce_low(20, n);
    check("t6_no_resume", n, 0);
    check("t6_busy", busy, 0);
    check("t6_ready", px_ready, 1);
    check("t6_drop_cleared", drop_count, 0);

    check("sb_empty", sb.size(), 0);
    check("write_total", n_writes, 22);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
